// File: rtl/regfile_mp.sv
// Multi-port general-purpose register file for the ID stage.
// NRD combinational read ports with same-cycle write bypass, two synchronous
// write ports (port 1 wins on an address clash) and a clear sequencer that
// zeroes the whole array after reset before any write is accepted.
module regfile_mp #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 32,
    parameter int ADDR_W  = 5,
    parameter int NRD     = 2,
    parameter int ZERO_R0 = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we0,
    input  logic [ADDR_W-1:0]     waddr0,
    input  logic [DATA_W-1:0]     wdata0,
    input  logic                  we1,
    input  logic [ADDR_W-1:0]     waddr1,
    input  logic [DATA_W-1:0]     wdata1,
    input  logic [NRD-1:0]        re,
    input  logic [NRD*ADDR_W-1:0] raddr,
    output logic [NRD*DATA_W-1:0] rdata,
    output logic                  init_busy,
    output logic                  wr_collide
);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [ADDR_W:0]    cnt_r;
    logic [ADDR_W:0]    cnt_next_s;
    logic               busy_next_s;
    logic               run_s;
    logic               last_clear_s;
    logic               wr0_ok_s;
    logic               wr1_ok_s;
    logic               collide_s;
    logic [DATA_W-1:0]  regs_r [DEPTH];

    assign run_s        = (state_r == ST_RUN);
    assign last_clear_s = (cnt_r == (ADDR_W+1)'(DEPTH - 1));

    // Write qualification: only in RUN, and register 0 is read-only when hardwired.
    always_comb begin
        wr0_ok_s  = 1'b0;
        wr1_ok_s  = 1'b0;
        collide_s = 1'b0;
        if (run_s) begin
            wr0_ok_s  = we0 && !((ZERO_R0 != 0) && (waddr0 == {ADDR_W{1'b0}}));
            wr1_ok_s  = we1 && !((ZERO_R0 != 0) && (waddr1 == {ADDR_W{1'b0}}));
            collide_s = wr0_ok_s && wr1_ok_s && (waddr0 == waddr1);
        end else begin
            wr0_ok_s  = 1'b0;
            wr1_ok_s  = 1'b0;
            collide_s = 1'b0;
        end
    end

    // Next-state logic for the clear sequencer: walk cnt over the array, then RUN.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        busy_next_s  = init_busy;
        case (state_r)
            ST_INIT: begin
                cnt_next_s = cnt_r + {{ADDR_W{1'b0}}, 1'b1};
                if (last_clear_s) begin
                    state_next_s = ST_RUN;
                    busy_next_s  = 1'b0;
                end else begin
                    state_next_s = ST_INIT;
                    busy_next_s  = 1'b1;
                end
            end
            ST_RUN: begin
                state_next_s = ST_RUN;
                cnt_next_s   = cnt_r;
                busy_next_s  = 1'b0;
            end
            default: begin
                state_next_s = ST_INIT;
                cnt_next_s   = {(ADDR_W+1){1'b0}};
                busy_next_s  = 1'b1;
            end
        endcase
    end

    // Control registers: reset restarts the clear sequence from register 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_INIT;
            cnt_r      <= {(ADDR_W+1){1'b0}};
            init_busy  <= 1'b1;
            wr_collide <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            cnt_r      <= cnt_next_s;
            init_busy  <= busy_next_s;
            wr_collide <= collide_s;
        end
    end

    // Array update: zero fill during INIT, prioritised dual write during RUN.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_r == ST_INIT) begin
                regs_r[cnt_r[ADDR_W-1:0]] <= {DATA_W{1'b0}};
            end else begin
                if (wr0_ok_s && !collide_s) begin
                    regs_r[waddr0] <= wdata0;
                end
                if (wr1_ok_s) begin
                    regs_r[waddr1] <= wdata1;
                end
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra_s;
        logic [DATA_W-1:0] rd_s;

        assign ra_s = raddr[k*ADDR_W +: ADDR_W];

        // Read mux: gated by reset/INIT/enable, then bypass (port 1 first), then array.
        always_comb begin
            rd_s = {DATA_W{1'b0}};
            if (rst || !run_s) begin
                rd_s = {DATA_W{1'b0}};
            end else if (!re[k]) begin
                rd_s = {DATA_W{1'b0}};
            end else if ((ZERO_R0 != 0) && (ra_s == {ADDR_W{1'b0}})) begin
                rd_s = {DATA_W{1'b0}};
            end else if (we1 && (waddr1 == ra_s)) begin
                rd_s = wdata1;
            end else if (we0 && (waddr0 == ra_s)) begin
                rd_s = wdata0;
            end else begin
                rd_s = regs_r[ra_s];
            end
        end

        assign rdata[k*DATA_W +: DATA_W] = rd_s;
    end

endmodule
